// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: input synchronizers, clock glitch filter, frame FSM
// with parity/stop/timeout checks, and make/break decoding of Space, Left and Right.
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_space,
   output logic       key_left,
   output logic       key_right,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [FW-1:0] FILT_ONE  = FW'(1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_ONE    = TW'(1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic          fclk_q, fclk_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [1:0]    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic          ext_q, ext_d, brk_q, brk_d;
   logic          key_space_q, key_space_d;
   logic          key_left_q, key_left_d;
   logic          key_right_q, key_right_d;
   logic [7:0]    scan_code_q, scan_code_d;
   logic          scan_valid_q, scan_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          fedge, timeout, accept, reject;

   always_comb begin
      clk_s1_d     = ps2_clk;
      clk_s2_d     = clk_s1_q;
      dat_s1_d     = ps2_data;
      dat_s2_d     = dat_s1_q;
      fclk_d       = fclk_q;
      filt_cnt_d   = '0;
      to_cnt_d     = to_cnt_q;
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      ext_d        = ext_q;
      brk_d        = brk_q;
      key_space_d  = key_space_q;
      key_left_d   = key_left_q;
      key_right_d  = key_right_q;
      scan_code_d  = scan_code_q;
      scan_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      fedge        = 1'b0;
      accept       = 1'b0;
      reject       = 1'b0;

      // fclk follows the synchronized clock only after FILTER_LEN differing cycles in a row
      if (clk_s2_q != fclk_q) begin
         if (filt_cnt_q == FILT_LAST) begin
            fclk_d = clk_s2_q;
            fedge  = fclk_q;
         end else begin
            filt_cnt_d = filt_cnt_q + FILT_ONE;
         end
      end

      if (state_q == S_IDLE || fedge) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != TO_MAX) begin
         to_cnt_d = to_cnt_q + TO_ONE;
      end
      timeout = (state_q != S_IDLE) && !fedge && (to_cnt_q == TO_LAST);

      case (state_q)
         S_IDLE: begin
            if (fedge && !dat_s2_q) begin
               state_d   = S_DATA;
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            if (fedge) begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            if (fedge) begin
               parity_d = dat_s2_q;
               state_d  = S_STOP;
            end
         end
         S_STOP: begin
            if (fedge) begin
               state_d = S_IDLE;
               if (dat_s2_q && (^{shift_q, parity_q})) accept = 1'b1;
               else                                     reject = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (timeout) begin
         state_d = S_IDLE;
         reject  = 1'b1;
      end

      if (accept) begin
         scan_code_d  = shift_q;
         scan_valid_d = 1'b1;
         if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
         end else begin
            if (ext_q && shift_q == 8'h6B)  key_left_d  = !brk_q;
            if (ext_q && shift_q == 8'h74)  key_right_d = !brk_q;
            if (!ext_q && shift_q == 8'h29) key_space_d = !brk_q;
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end

      // a dropped frame may have been the second half of a prefix sequence
      if (reject) begin
         frame_err_d = 1'b1;
         ext_d       = 1'b0;
         brk_d       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q     <= 1'b1;
         clk_s2_q     <= 1'b1;
         dat_s1_q     <= 1'b1;
         dat_s2_q     <= 1'b1;
         fclk_q       <= 1'b1;
         filt_cnt_q   <= '0;
         to_cnt_q     <= '0;
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
         key_space_q  <= 1'b0;
         key_left_q   <= 1'b0;
         key_right_q  <= 1'b0;
         scan_code_q  <= '0;
         scan_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         clk_s1_q     <= clk_s1_d;
         clk_s2_q     <= clk_s2_d;
         dat_s1_q     <= dat_s1_d;
         dat_s2_q     <= dat_s2_d;
         fclk_q       <= fclk_d;
         filt_cnt_q   <= filt_cnt_d;
         to_cnt_q     <= to_cnt_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         ext_q        <= ext_d;
         brk_q        <= brk_d;
         key_space_q  <= key_space_d;
         key_left_q   <= key_left_d;
         key_right_q  <= key_right_d;
         scan_code_q  <= scan_code_d;
         scan_valid_q <= scan_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign key_space  = key_space_q;
   assign key_left   = key_left_q;
   assign key_right  = key_right_q;
   assign scan_code  = scan_code_q;
   assign scan_valid = scan_valid_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: drives PS/2 frames bit by bit and compares the
// outputs against a byte-level make/break model with an expected scan-code queue.
module tb_ps2_key_decoder;

   localparam int FILTER_LEN     = 8;
   localparam int TIMEOUT_CYCLES = 2000;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       key_space, key_left, key_right;
   logic [7:0] scan_code;
   logic       scan_valid, frame_err;

   always #5 clk = ~clk;

   ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_space(key_space), .key_left(key_left), .key_right(key_right),
      .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model: held keys, prefix flags, expected byte stream and error count
   logic       m_space, m_left, m_right, m_ext, m_brk;
   logic [7:0] m_code;
   logic [7:0] exp_q[$];
   int         exp_err = 0;
   int         got_err = 0;
   int         bad_valid = 0;
   int         overlap = 0;
   int         half = 20;

   task automatic model_reset();
      m_space = 0; m_left = 0; m_right = 0; m_ext = 0; m_brk = 0; m_code = 8'h00;
   endtask

   task automatic model_byte(input logic [7:0] b, input bit ok);
      if (!ok) begin
         exp_err++;
         m_ext = 0;
         m_brk = 0;
      end else begin
         exp_q.push_back(b);
         m_code = b;
         if (b == 8'hF0) m_brk = 1;
         else if (b == 8'hE0) m_ext = 1;
         else begin
            if (m_ext && b == 8'h6B) m_left = !m_brk;
            if (m_ext && b == 8'h74) m_right = !m_brk;
            if (!m_ext && b == 8'h29) m_space = !m_brk;
            m_ext = 0;
            m_brk = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) got_err++;
         if (scan_valid && frame_err) overlap++;
         if (scan_valid) begin
            if (exp_q.size() > 0) check("scan_code", 32'(scan_code), 32'(exp_q.pop_front()));
            else bad_valid++;
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_cycles(half);
      ps2_clk = 1'b0;
      wait_cycles(half);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic par;
      par = (~^b) ^ bad_par;
      model_byte(b, !bad_par && !bad_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(par);
      send_bit(!bad_stop);
      ps2_data = 1'b1;
      wait_cycles(half);
   endtask

   task automatic check_state(input string tag);
      @(negedge clk);
      check({tag, ".space"}, 32'(key_space), 32'(m_space));
      check({tag, ".left"}, 32'(key_left), 32'(m_left));
      check({tag, ".right"}, 32'(key_right), 32'(m_right));
      check({tag, ".code"}, 32'(scan_code), 32'(m_code));
      check({tag, ".errs"}, 32'(got_err), 32'(exp_err));
      check({tag, ".pending"}, 32'(exp_q.size()), 32'd0);
      check({tag, ".spurious"}, 32'(bad_valid), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int         sel, cor;
      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
      model_reset();
      wait_cycles(5);
      @(negedge clk) rst = 1'b0;
      check_state("reset");

      send_frame(8'h29, 0, 0);
      check_state("space_make");
      send_frame(8'hF0, 0, 0); send_frame(8'h29, 0, 0);
      check_state("space_break");

      send_frame(8'hE0, 0, 0); send_frame(8'h6B, 0, 0);
      send_frame(8'hE0, 0, 0); send_frame(8'h74, 0, 0);
      check_state("left_right_make");
      send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h6B, 0, 0);
      check_state("left_break");

      send_frame(8'h6B, 0, 0);
      check_state("keypad_6b");
      send_frame(8'hE0, 0, 0); send_frame(8'h6B, 0, 0);
      check_state("left_again");
      send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h6B, 0, 0);

      send_frame(8'h29, 1, 0);
      send_frame(8'h29, 0, 1);
      check_state("bad_frames");
      send_frame(8'hE0, 0, 0); send_frame(8'h6B, 1, 0); send_frame(8'h6B, 0, 0);
      check_state("prefix_cleared");

      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
      ps2_data = 1'b1;
      exp_err++; m_ext = 0; m_brk = 0;
      wait_cycles(TIMEOUT_CYCLES + 50);
      check_state("timeout");
      send_frame(8'h29, 0, 0);
      check_state("after_timeout");

      ps2_data = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ps2_clk = 1'b0;
         wait_cycles(3);
         ps2_clk = 1'b1;
         wait_cycles(20);
      end
      ps2_data = 1'b1;
      wait_cycles(TIMEOUT_CYCLES + 50);
      check_state("glitches");

      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      ps2_data = 1'b1;
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      check("rst.space", 32'(key_space), 32'd0);
      check("rst.valid", 32'(scan_valid), 32'd0);
      check("rst.err", 32'(frame_err), 32'd0);
      rst = 1'b0;
      model_reset();
      wait_cycles(10);
      check_state("after_rst");
      send_frame(8'h29, 0, 0);
      check_state("frame_after_rst");

      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1:    b = 8'h29;
            2:       b = 8'hE0;
            3:       b = 8'hF0;
            4:       b = 8'h6B;
            5:       b = 8'h74;
            6:       b = 8'hAA;
            default: b = 8'($urandom_range(0, 255));
         endcase
         cor  = $urandom_range(0, 9);
         half = $urandom_range(16, 30);
         send_frame(b, cor == 0, cor == 1);
         if (n % 4 == 3) check_state("random");
      end
      check_state("random_end");
      check("valid_err_overlap", 32'(overlap), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
